card_blitter: RTL and testbench

Sprite-copy engine that drives the card-image ROM lookup (`Mem_pixel`) as its initiator and writes the returned pixels into a 12-bit RGB frame buffer. On a `start` request it scans one 32×46 card image in row-major order at one pixel per clock. It accounts for the ROM's one-cycle read latency, clips against the frame-buffer edges, skips colour-key pixels, and signals completion. It sits between the game/table logic that places cards and the frame-buffer write port read by the VGA scan-out.

---
 rtl/card_blitter.sv | 170 +++++++++++++++++
 tb/tb_card_blitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_blitter.sv
// Card sprite blitter: scans a 32x46 card image from the card ROM at one pixel per
// clock, clips it against the frame-buffer edges, drops colour-key pixels and writes
// the rest into the frame buffer.
module card_blitter #(
  parameter int unsigned FB_W        = 320,
  parameter int unsigned FB_H        = 240,
  parameter int unsigned XW          = 9,
  parameter int unsigned YW          = 8,
  parameter int unsigned AW          = 17,
  parameter int unsigned TRANS_EN    = 1,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic          clk_25MHz,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [5:0]    card_type,
  input  logic [XW-1:0] dst_x,
  input  logic [YW-1:0] dst_y,
  output logic [5:0]    rom_card_type,
  output logic [5:0]    rom_pixel_x,
  output logic [5:0]    rom_pixel_y,
  input  logic [11:0]   rom_pixel,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [11:0]   fb_data,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [4:0]    px_q, px_d;
  logic [5:0]    py_q, py_d;
  logic [5:0]    card_q, card_d;
  logic [XW-1:0] dx_q, dx_d;
  logic [YW-1:0] dy_q, dy_d;
  logic          drain_q, drain_d;
  logic          done_q, done_d;

  // Stage 1: pixel whose ROM data arrives this cycle.
  logic          v1_q, v1_d;
  logic [4:0]    px1_q, px1_d;
  logic [5:0]    py1_q, py1_d;

  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [11:0]   fb_data_q, fb_data_d;

  logic [XW:0]   sx;
  logic [YW:0]   sy;
  logic          key_hit;

  // Scan sequencing: IDLE -> RUN (1472 issues) -> DRAIN (2 cycles) -> IDLE.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    card_d  = card_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    v1_d    = 1'b0;
    px1_d   = px1_q;
    py1_d   = py1_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          card_d  = card_type;
          dx_d    = dst_x;
          dy_d    = dst_y;
          px_d    = '0;
          py_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          v1_d  = 1'b1;
          px1_d = px_q;
          py1_d = py_q;
          if (px_q == 5'd31) begin
            px_d = '0;
            if (py_q == 6'd45) begin
              py_d    = '0;
              drain_d = 1'b0;
              state_d = StDrain;
            end else begin
              py_d = py_q + 6'd1;
            end
          end else begin
            px_d = px_q + 5'd1;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (drain_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write stage: screen position, clipping and colour key for the stage-1 pixel.
  always_comb begin
    sx        = {1'b0, dx_q} + (XW+1)'(px1_q);
    sy        = {1'b0, dy_q} + (YW+1)'(py1_q);
    key_hit   = (TRANS_EN != 0) && (rom_pixel == TRANSPARENT);
    fb_we_d   = v1_q && (32'(sx) < FB_W) && (32'(sy) < FB_H) && !key_hit;
    fb_addr_d = AW'(sy) * AW'(FB_W) + AW'(sx);
    fb_data_d = rom_pixel;
  end

  // State, counters, stage-1 pipeline and registered write port.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      px_q      <= '0;
      py_q      <= '0;
      card_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      px1_q     <= '0;
      py1_q     <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      card_q    <= card_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
      px1_q     <= px1_d;
      py1_q     <= py1_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign rom_card_type = card_q;
  assign rom_pixel_x   = {1'b0, px_q};
  assign rom_pixel_y   = py_q;
  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_data       = fb_data_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule

// File: tb/tb_card_blitter.sv
// Scoreboard bench for card_blitter: stimulus pushes every expected frame-buffer write
// (address, data, cycle); a negedge monitor pops and compares each DUT write.
module tb_card_blitter;

  localparam int unsigned FB_W = 320;
  localparam int unsigned FB_H = 240;

  logic        clk_25MHz = 1'b0;
  logic        rst, start, abort;
  logic [5:0]  card_type;
  logic [8:0]  dst_x;
  logic [7:0]  dst_y;
  logic [5:0]  rom_card_type, rom_pixel_x, rom_pixel_y;
  logic [11:0] rom_pixel;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        busy, done;

  typedef struct {
    int unsigned addr;
    logic [11:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  done_seen   = 0;
  bit  inject_key  = 1'b0;

  card_blitter dut (
    .clk_25MHz    (clk_25MHz),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .card_type    (card_type),
    .dst_x        (dst_x),
    .dst_y        (dst_y),
    .rom_card_type(rom_card_type),
    .rom_pixel_x  (rom_pixel_x),
    .rom_pixel_y  (rom_pixel_y),
    .rom_pixel    (rom_pixel),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .busy         (busy),
    .done         (done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  // Card ROM contents: out-of-range cards read 12'h68A; optional key pixel at (5,3).
  function automatic logic [11:0] rom_fn(input logic [5:0] c, input logic [5:0] x,
                                         input logic [5:0] y, input bit key);
    if (c >= 6'd54) return 12'h68A;
    if (key && x == 6'd5 && y == 6'd3) return 12'hF0F;
    return {y ^ c, x};
  endfunction

  // One-cycle-latency ROM.
  always @(posedge clk_25MHz)
    rom_pixel <= rom_fn(rom_card_type, rom_pixel_x, rom_pixel_y, inject_key);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_fb_we"}, 32'(fb_we), 0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 0);
    check({tag, "_fb_data"}, 32'(fb_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rom_x"}, 32'(rom_pixel_x), 0);
    check({tag, "_rom_y"}, 32'(rom_pixel_y), 0);
    check({tag, "_rom_card"}, 32'(rom_card_type), 0);
  endtask

  // Expected writes of a blit whose start is sampled in cycle c0.
  task automatic push_blit(input int c0, input logic [5:0] c, input int dx, input int dy,
                           input bit key);
    for (int y = 0; y < 46; y++) begin
      for (int x = 0; x < 32; x++) begin
        int unsigned sx, sy;
        logic [11:0] d;
        wr_t w;
        sx = dx + x;
        sy = dy + y;
        d  = rom_fn(c, 6'(x), 6'(y), key);
        if (sx < FB_W && sy < FB_H && d != 12'hF0F) begin
          w.addr = sy * FB_W + sx;
          w.data = d;
          w.cyc  = c0 + 3 + y * 32 + x;
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle c0).
  task automatic start_blit(input logic [5:0] c, input int dx, input int dy, input bit key,
                            output int c0);
    card_type  = c;
    dst_x      = 9'(dx);
    dst_y      = 8'(dy);
    inject_key = key;
    start      = 1'b1;
    c0         = cyc;
    push_blit(c0, c, dx, dy, key);
    @(negedge clk_25MHz);
    start = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk_25MHz);
  endtask

  // Bounded wait for done; checks its cycle and that every expected write happened.
  task automatic wait_done(input int c0, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1600) begin
      @(negedge clk_25MHz);
      n++;
    end
    check({name, "_done_cycle"}, 32'(cyc - c0), 1475);
    check({name, "_busy_at_done"}, 32'(busy), 0);
    check({name, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  // Monitor: every DUT write must match the head of the expectation queue.
  always @(negedge clk_25MHz) begin : monitor
    wr_t w;
    if (done === 1'b1) done_seen++;
    if (fb_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %h in cycle %0d, required none",
                 fb_addr, fb_data, cyc);
      end else begin
        w = exp_q.pop_front();
        if (fb_addr !== 17'(w.addr) || fb_data !== w.data || cyc != w.cyc) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                   fb_addr, fb_data, cyc, w.addr, w.data, w.cyc);
        end
      end
    end
  end

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, dseen;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    card_type = '0; dst_x = '0; dst_y = '0;
    repeat (2) @(negedge clk_25MHz);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk_25MHz);

    // Card 0 at origin, with a start in cycle 500 that must be ignored.
    start_blit(6'd0, 0, 0, 1'b0, c0);
    check("rom_card_latched", 32'(rom_card_type), 0);
    wait_to(c0 + 500);
    check("busy_mid_blit", 32'(busy), 1);
    start = 1'b1; card_type = 6'd7; dst_x = 9'd10; dst_y = 8'd10;
    @(negedge clk_25MHz);
    start = 1'b0;
    check("card_held_after_ignored_start", 32'(rom_card_type), 0);
    wait_done(c0, "blit_card0");

    // Start in the done cycle: corner card clipped to 20x20.
    start_blit(6'd14, 300, 220, 1'b0, c0);
    check("busy_after_back_to_back_start", 32'(busy), 1);
    check("rom_card_14", 32'(rom_card_type), 14);
    wait_done(c0, "blit_clipped");

    // Colour key at (5,3).
    start_blit(6'd5, 20, 30, 1'b1, c0);
    wait_done(c0, "blit_key");

    // Out-of-range card.
    start_blit(6'd60, 100, 50, 1'b0, c0);
    wait_done(c0, "blit_card60");
    @(negedge clk_25MHz);

    // Abort in cycle 100 with a simultaneous start.
    start_blit(6'd3, 40, 40, 1'b0, c0);
    wait_to(c0 + 100);
    abort = 1'b1; start = 1'b1; card_type = 6'd9;
    @(negedge clk_25MHz);
    abort = 1'b0; start = 1'b0;
    check("busy_after_abort", 32'(busy), 0);
    dseen = done_seen;
    wait_to(c0 + 104);
    exp_q.delete();
    repeat (1500) @(negedge clk_25MHz);
    check("no_done_after_abort", 32'(done_seen), 32'(dseen));
    start_blit(6'd9, 10, 10, 1'b0, c0);
    wait_done(c0, "blit_after_abort");
    @(negedge clk_25MHz);

    // Asynchronous reset pulse between edges in cycle 700.
    start_blit(6'd14, 0, 0, 1'b0, c0);
    wait_to(c0 + 700);
    @(posedge clk_25MHz);
    #5 rst = 1'b1;
    #5 check_reset_outs("async_reset");
    exp_q.delete();
    dseen = done_seen;
    #5 rst = 1'b0;
    repeat (60) @(negedge clk_25MHz);
    check("no_done_after_reset", 32'(done_seen), 32'(dseen));
    check("idle_after_reset", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
